// File: rtl/math_game_pkg.sv
// Shared types and constants for the math game: FSM states, round verdicts and BCD helpers.
package math_game_pkg;

    localparam int unsigned BCD_W = 4;
    localparam logic [BCD_W-1:0] BCD_MAX_DIGIT = 4'd9;

    typedef logic [BCD_W-1:0] bcd_digit_t;

    typedef enum logic [2:0] {
        StIdle     = 3'd0,
        StLoad     = 3'd1,
        StSettle   = 3'd2,
        StRun      = 3'd3,
        StFeedback = 3'd4,
        StOver     = 3'd5
    } state_e;

    typedef enum logic [1:0] {
        JudgeNone    = 2'd0,
        JudgeCorrect = 2'd1,
        JudgeWrong   = 2'd2
    } judge_e;

    function automatic logic [3:0] sat_inc4(input logic [3:0] val, input logic [3:0] max_val);
        return (val >= max_val) ? val : val + 4'd1;
    endfunction

    function automatic bcd_digit_t bcd_digit_inc(input bcd_digit_t val);
        return (val >= BCD_MAX_DIGIT) ? '0 : val + bcd_digit_t'(1);
    endfunction

endpackage

// File: rtl/bcd2_sat_counter.sv
// Two-digit BCD counter with synchronous clear and increment that saturates at 99.
module bcd2_sat_counter
    import math_game_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       clr_i,
    input  logic       inc_i,
    output bcd_digit_t tens_o,
    output bcd_digit_t ones_o
);

    bcd_digit_t tens_q, tens_d;
    bcd_digit_t ones_q, ones_d;
    logic       at_max;

    assign at_max = (tens_q == BCD_MAX_DIGIT) && (ones_q == BCD_MAX_DIGIT);

    always_comb begin
        tens_d = tens_q;
        ones_d = ones_q;
        if (clr_i) begin
            tens_d = '0;
            ones_d = '0;
        end else if (inc_i && !at_max) begin
            ones_d = bcd_digit_inc(ones_q);
            if (ones_q == BCD_MAX_DIGIT) begin
                tens_d = bcd_digit_inc(tens_q);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tens_q <= '0;
            ones_q <= '0;
        end else begin
            tens_q <= tens_d;
            ones_q <= ones_d;
        end
    end

    assign tens_o = tens_q;
    assign ones_o = ones_q;

endmodule

// File: rtl/math_round_ctrl.sv
// Game-round controller: sequences problem/timer per round, judges answers,
// and keeps score, lives and difficulty for the countdown timer.
module math_round_ctrl
    import math_game_pkg::*;
#(
    parameter int unsigned  LIVES      = 3,
    parameter int unsigned  STREAK_LEN = 3,
    parameter logic [3:0]   DIFF_INIT  = 4'd1,
    parameter logic [3:0]   DIFF_MAX   = 4'd9,
    parameter logic [25:0]  FB_CYCLES  = 26'd50_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       answer_valid,
    input  logic [7:0] answer_bcd,
    input  logic [7:0] expected_bcd,
    input  logic       time_out,
    output logic       timer_en,
    output logic       timer_reconfig,
    output logic [3:0] difficulty,
    output logic       new_problem,
    output logic [3:0] score_tens,
    output logic [3:0] score_ones,
    output logic [2:0] lives,
    output logic       fb_correct,
    output logic       fb_wrong,
    output logic       game_over
);

    localparam logic [2:0]  LivesInit = 3'(LIVES);
    localparam logic [3:0]  StreakTop = 4'(STREAK_LEN);
    localparam logic [25:0] FbLast    = FB_CYCLES - 26'd1;

    state_e      state_q, state_d;
    judge_e      judge;
    logic        fb_last;
    logic        game_init;

    logic [2:0]  lives_q, lives_d;
    logic [3:0]  diff_q, diff_d;
    logic [3:0]  streak_q, streak_d;
    logic [25:0] fb_cnt_q, fb_cnt_d;

    logic        timer_en_q, timer_en_d;
    logic        timer_reconfig_q, timer_reconfig_d;
    logic        new_problem_q, new_problem_d;
    logic        fb_correct_q, fb_correct_d;
    logic        fb_wrong_q, fb_wrong_d;
    logic        game_over_q, game_over_d;

    assign fb_last   = (fb_cnt_q == FbLast);
    assign game_init = ((state_q == StIdle) || (state_q == StOver)) && start;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and round verdict; time_out outranks a same-cycle answer.
    always_comb begin
        state_d = state_q;
        judge   = JudgeNone;
        unique case (state_q)
            StIdle, StOver: begin
                if (start) begin
                    state_d = StLoad;
                end
            end
            StLoad:   state_d = StSettle;
            StSettle: state_d = StRun;
            StRun: begin
                if (time_out) begin
                    judge   = JudgeWrong;
                    state_d = StFeedback;
                end else if (answer_valid) begin
                    judge   = (answer_bcd == expected_bcd) ? JudgeCorrect : JudgeWrong;
                    state_d = StFeedback;
                end
            end
            StFeedback: begin
                if (fb_last) begin
                    state_d = (lives_q == 3'd0) ? StOver : StLoad;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Game bookkeeping: lives, streak, difficulty and the feedback hold counter
    always_comb begin
        lives_d  = lives_q;
        diff_d   = diff_q;
        streak_d = streak_q;
        fb_cnt_d = '0;

        if (game_init) begin
            lives_d  = LivesInit;
            diff_d   = DIFF_INIT;
            streak_d = '0;
        end else if (judge == JudgeCorrect) begin
            if (streak_q + 4'd1 >= StreakTop) begin
                streak_d = '0;
                diff_d   = sat_inc4(diff_q, DIFF_MAX);
            end else begin
                streak_d = streak_q + 4'd1;
            end
        end else if (judge == JudgeWrong) begin
            lives_d  = (lives_q == 3'd0) ? 3'd0 : lives_q - 3'd1;
            streak_d = '0;
        end

        if ((state_q == StFeedback) && !fb_last) begin
            fb_cnt_d = fb_cnt_q + 26'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lives_q  <= LivesInit;
            diff_q   <= DIFF_INIT;
            streak_q <= '0;
            fb_cnt_q <= '0;
        end else begin
            lives_q  <= lives_d;
            diff_q   <= diff_d;
            streak_q <= streak_d;
            fb_cnt_q <= fb_cnt_d;
        end
    end

    // Outputs are decoded from the next state so they flip on the same edge as the FSM.
    always_comb begin
        timer_en_d       = (state_d == StRun);
        timer_reconfig_d = (state_d == StLoad);
        new_problem_d    = (state_d == StLoad);
        game_over_d      = (state_d == StOver);
        fb_correct_d     = (state_d == StFeedback) &&
                           ((judge == JudgeCorrect) || ((state_q == StFeedback) && fb_correct_q));
        fb_wrong_d       = (state_d == StFeedback) &&
                           ((judge == JudgeWrong) || ((state_q == StFeedback) && fb_wrong_q));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            timer_en_q       <= 1'b0;
            timer_reconfig_q <= 1'b0;
            new_problem_q    <= 1'b0;
            fb_correct_q     <= 1'b0;
            fb_wrong_q       <= 1'b0;
            game_over_q      <= 1'b0;
        end else begin
            timer_en_q       <= timer_en_d;
            timer_reconfig_q <= timer_reconfig_d;
            new_problem_q    <= new_problem_d;
            fb_correct_q     <= fb_correct_d;
            fb_wrong_q       <= fb_wrong_d;
            game_over_q      <= game_over_d;
        end
    end

    bcd2_sat_counter u_score (
        .clk    (clk),
        .reset  (reset),
        .clr_i  (game_init),
        .inc_i  (judge == JudgeCorrect),
        .tens_o (score_tens),
        .ones_o (score_ones)
    );

    assign timer_en       = timer_en_q;
    assign timer_reconfig = timer_reconfig_q;
    assign new_problem    = new_problem_q;
    assign fb_correct     = fb_correct_q;
    assign fb_wrong       = fb_wrong_q;
    assign game_over      = game_over_q;
    assign lives          = lives_q;
    assign difficulty     = diff_q;

endmodule

// File: tb/tb_math_round_ctrl.sv
// Directed bench for math_round_ctrl: table of judged rounds plus hand-written
// start, game-over, saturation and asynchronous-reset sequences.
module tb_math_round_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       answer_valid;
    logic [7:0] answer_bcd;
    logic [7:0] expected_bcd;
    logic       time_out;
    logic       timer_en;
    logic       timer_reconfig;
    logic [3:0] difficulty;
    logic       new_problem;
    logic [3:0] score_tens;
    logic [3:0] score_ones;
    logic [2:0] lives;
    logic       fb_correct;
    logic       fb_wrong;
    logic       game_over;

    int tests  = 0;
    int failed = 0;

    // kind: 0 answer only, 1 time_out only, 2 time_out with answer
    typedef struct {
        logic [1:0] kind;
        logic [7:0] ans;
        logic [7:0] exp;
        logic       ok;
        logic [7:0] score;
        logic [2:0] lives;
        logic [3:0] diff;
    } vec_t;

    vec_t vecs[8];

    math_round_ctrl #(
        .LIVES      (3),
        .STREAK_LEN (3),
        .DIFF_INIT  (4'd1),
        .DIFF_MAX   (4'd9),
        .FB_CYCLES  (26'd4)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .answer_valid   (answer_valid),
        .answer_bcd     (answer_bcd),
        .expected_bcd   (expected_bcd),
        .time_out       (time_out),
        .timer_en       (timer_en),
        .timer_reconfig (timer_reconfig),
        .difficulty     (difficulty),
        .new_problem    (new_problem),
        .score_tens     (score_tens),
        .score_ones     (score_ones),
        .lives          (lives),
        .fb_correct     (fb_correct),
        .fb_wrong       (fb_wrong),
        .game_over      (game_over)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            failed++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] to_bcd(input int k);
        int s;
        s = (k > 99) ? 99 : k;
        return {4'(s / 10), 4'(s % 10)};
    endfunction

    task automatic do_round(input logic [1:0] kind, input logic [7:0] ans, input logic [7:0] exp,
                            input logic ok, input logic [7:0] exp_score,
                            input logic [2:0] exp_lives, input logic [3:0] exp_diff,
                            input string tag);
        int n;
        int fb_len;
        expected_bcd = exp;
        n = 0;
        while (!timer_en && n < 30) begin
            step();
            n++;
        end
        if (!timer_en) begin
            check({tag, "_reach_run"}, 32'd0, 32'd1);
            return;
        end
        answer_valid = (kind != 2'd1);
        answer_bcd   = ans;
        time_out     = (kind != 2'd0);
        step();
        answer_valid = 1'b0;
        time_out     = 1'b0;
        check({tag, "_fb_correct"}, 32'(fb_correct), 32'(ok));
        check({tag, "_fb_wrong"}, 32'(fb_wrong), 32'(!ok));
        check({tag, "_score"}, 32'({score_tens, score_ones}), 32'(exp_score));
        check({tag, "_lives"}, 32'(lives), 32'(exp_lives));
        check({tag, "_diff"}, 32'(difficulty), 32'(exp_diff));
        check({tag, "_timer_en_off"}, 32'(timer_en), 32'd0);
        fb_len = 0;
        n = 0;
        while ((fb_correct || fb_wrong) && n < 20) begin
            fb_len++;
            step();
            n++;
        end
        check({tag, "_fb_len"}, 32'(fb_len), 32'd4);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, tests %0d failed %0d", tests, failed);
        $fatal(1);
    end

    initial begin
        int n;
        logic [7:0] v;

        vecs[0] = '{2'd0, 8'h42, 8'h42, 1'b1, 8'h01, 3'd3, 4'd1};
        vecs[1] = '{2'd0, 8'h13, 8'h13, 1'b1, 8'h02, 3'd3, 4'd1};
        vecs[2] = '{2'd0, 8'h99, 8'h99, 1'b1, 8'h03, 3'd3, 4'd2};
        vecs[3] = '{2'd0, 8'h17, 8'h71, 1'b0, 8'h03, 3'd2, 4'd2};
        vecs[4] = '{2'd0, 8'h05, 8'h05, 1'b1, 8'h04, 3'd2, 4'd2};
        vecs[5] = '{2'd2, 8'h05, 8'h05, 1'b0, 8'h04, 3'd1, 4'd2};
        vecs[6] = '{2'd0, 8'hAB, 8'hAB, 1'b1, 8'h05, 3'd1, 4'd2};
        vecs[7] = '{2'd1, 8'h3F, 8'h39, 1'b0, 8'h05, 3'd0, 4'd2};

        reset        = 1'b1;
        start        = 1'b0;
        answer_valid = 1'b0;
        answer_bcd   = 8'h00;
        expected_bcd = 8'h00;
        time_out     = 1'b0;
        #12;
        check("rst_timer_en", 32'(timer_en), 32'd0);
        check("rst_pulses", 32'({timer_reconfig, new_problem, fb_correct, fb_wrong, game_over}), 32'd0);
        check("rst_score", 32'({score_tens, score_ones}), 32'h00);
        check("rst_lives", 32'(lives), 32'd3);
        check("rst_diff", 32'(difficulty), 32'd1);
        @(posedge clk);
        #1;
        reset = 1'b0;
        step();
        check("idle_timer_en", 32'(timer_en), 32'd0);

        // Start: LOAD, SETTLE (answer there must be ignored), then RUN
        start = 1'b1;
        step();
        start = 1'b0;
        check("load_reconfig", 32'(timer_reconfig), 32'd1);
        check("load_new_problem", 32'(new_problem), 32'd1);
        check("load_timer_en", 32'(timer_en), 32'd0);
        step();
        check("settle_pulses", 32'({timer_reconfig, new_problem, timer_en}), 32'd0);
        answer_valid = 1'b1;
        answer_bcd   = 8'h00;
        expected_bcd = 8'h42;
        step();
        answer_valid = 1'b0;
        check("run_timer_en", 32'(timer_en), 32'd1);
        check("settle_ans_ignored_lives", 32'(lives), 32'd3);
        check("settle_ans_ignored_fb", 32'({fb_correct, fb_wrong}), 32'd0);

        for (int i = 0; i < 8; i++) begin
            do_round(vecs[i].kind, vecs[i].ans, vecs[i].exp, vecs[i].ok, vecs[i].score,
                     vecs[i].lives, vecs[i].diff, $sformatf("vec%0d", i));
        end

        check("over_game_over", 32'(game_over), 32'd1);
        check("over_timer_en", 32'(timer_en), 32'd0);
        check("over_lives", 32'(lives), 32'd0);
        answer_valid = 1'b1;
        answer_bcd   = 8'h39;
        expected_bcd = 8'h39;
        time_out     = 1'b1;
        step();
        answer_valid = 1'b0;
        time_out     = 1'b0;
        step();
        check("over_score_held", 32'({score_tens, score_ones}), 32'h05);
        check("over_still_over", 32'(game_over), 32'd1);

        // Restart from OVER reinitialises in the same edge
        start = 1'b1;
        step();
        start = 1'b0;
        check("restart_score", 32'({score_tens, score_ones}), 32'h00);
        check("restart_lives", 32'(lives), 32'd3);
        check("restart_diff", 32'(difficulty), 32'd1);
        check("restart_load", 32'({timer_reconfig, game_over}), 32'b10);

        // Long run of correct answers: 09->10, difficulty to 9, score saturates at 99
        for (int k = 1; k <= 100; k++) begin
            v = {4'(k % 10), 4'((k * 3) % 10)};
            do_round(2'd0, v, v, 1'b1, to_bcd(k), 3'd3,
                     4'((1 + k / 3) > 9 ? 9 : (1 + k / 3)), $sformatf("corr%0d", k));
        end

        // Asynchronous reset in the middle of RUN
        n = 0;
        while (!timer_en && n < 30) begin
            step();
            n++;
        end
        check("pre_reset_in_run", 32'(timer_en), 32'd1);
        repeat (10) step();
        #2;
        reset = 1'b1;
        #1;
        check("async_rst_timer_en", 32'(timer_en), 32'd0);
        check("async_rst_score", 32'({score_tens, score_ones}), 32'h00);
        check("async_rst_lives", 32'(lives), 32'd3);
        check("async_rst_diff", 32'(difficulty), 32'd1);
        @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (3) step();
        check("post_rst_idle", 32'({timer_en, timer_reconfig, game_over}), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
